// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - state codes and control-word decode for the game sequencer
// Shared by unidade_controle_jogo and the top-level debug decoder, which turns
// db_estado into hex display digits using the same codes.
package jogo_pkg;

  // State codes exported on db_estado; the encoding is fixed because the hex
  // displays at the top level are decoded from these values.
  localparam logic [4:0] INICIAL            = 5'h00;
  localparam logic [4:0] PREPARACAO         = 5'h01;
  localparam logic [4:0] ESPERA_MACRO       = 5'h02;
  localparam logic [4:0] REGISTRA_MACRO     = 5'h03;
  localparam logic [4:0] VALIDA_MACRO       = 5'h04;
  localparam logic [4:0] ESPERA_MICRO       = 5'h05;
  localparam logic [4:0] REGISTRA_MICRO     = 5'h06;
  localparam logic [4:0] VALIDA_MICRO       = 5'h07;
  localparam logic [4:0] REGISTRA_JOGADA    = 5'h08;
  localparam logic [4:0] ATUALIZA_MACRO     = 5'h09;
  localparam logic [4:0] ESPERA_ATUALIZACAO = 5'h0A;
  localparam logic [4:0] TRANSMITE          = 5'h0B;
  localparam logic [4:0] VERIFICA_FIM       = 5'h0C;
  localparam logic [4:0] TROCA              = 5'h0D;
  localparam logic [4:0] VALIDA_PROXIMA     = 5'h0E;
  localparam logic [4:0] REGISTRA_PROXIMA   = 5'h0F;
  localparam logic [4:0] FIM                = 5'h10;

  // Every strobe the sequencer drives, gathered so the decode is one function.
  typedef struct packed {
    logic zera_edge;
    logic zera_r_micro;
    logic zera_r_macro;
    logic zera_flip_flop_t;
    logic zera_ram;
    logic zera_t;
    logic zera_s;
    logic registra_r_micro;
    logic registra_r_macro;
    logic we_board;
    logic we_board_state;
    logic troca_jogador;
    logic conta_t;
    logic conta_s;
    logic sinal_macro;
    logic sinal_valida_macro;
    logic transmitindo;
    logic pronto;
  } controle_t;

  // Moore decode: the control word depends on the state code only.
  // Unused codes decode to all-zero so a corrupted state is harmless for the
  // one cycle it takes to fall back to INICIAL.
  function automatic controle_t decodifica(input logic [4:0] estado);
    controle_t c;
    c = '0;
    case (estado)
      PREPARACAO: begin
        c.zera_edge        = 1'b1;
        c.zera_r_micro     = 1'b1;
        c.zera_r_macro     = 1'b1;
        c.zera_flip_flop_t = 1'b1;
        c.zera_ram         = 1'b1;
        c.zera_t           = 1'b1;
        c.zera_s           = 1'b1;
      end
      ESPERA_MACRO: begin
        c.sinal_macro = 1'b1;
      end
      REGISTRA_MACRO: begin
        c.sinal_macro      = 1'b1;
        c.registra_r_macro = 1'b1;
      end
      VALIDA_MACRO: begin
        c.sinal_valida_macro = 1'b1;
      end
      REGISTRA_MICRO: begin
        c.registra_r_micro = 1'b1;
      end
      REGISTRA_JOGADA: begin
        // Clearing the settle counter here gives espera_atualizacao a zero
        // count on entry.
        c.we_board = 1'b1;
        c.zera_t   = 1'b1;
      end
      ATUALIZA_MACRO: begin
        // Same for the transmit counter, cleared two states before transmite.
        c.we_board_state     = 1'b1;
        c.sinal_valida_macro = 1'b1;
        c.zera_s             = 1'b1;
      end
      ESPERA_ATUALIZACAO: begin
        c.conta_t = 1'b1;
      end
      TRANSMITE: begin
        c.conta_s      = 1'b1;
        c.transmitindo = 1'b1;
      end
      TROCA: begin
        c.troca_jogador = 1'b1;
      end
      REGISTRA_PROXIMA: begin
        // sinal_macro stays 0: the macro register loads the last micro index.
        c.registra_r_macro = 1'b1;
      end
      FIM: begin
        c.pronto = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// rtl/unidade_controle_jogo_if.sv - control/status bundle between sequencer and fluxo_dados
// master: the sequencer (drives clears/enables/selects, reads status flags)
// slave : the datapath (reads clears/enables/selects, drives status flags)
interface unidade_controle_jogo_if;

  // Status flags from the datapath
  logic tem_jogada;
  logic macro_vencida;
  logic micro_jogada;
  logic fim_jogo;
  logic fimT;
  logic fimS;

  // Clears
  logic zeraEdge;
  logic zeraR_micro;
  logic zeraR_macro;
  logic zeraFlipFlopT;
  logic zeraRAM;
  logic zeraT;
  logic zeraS;

  // Enables
  logic registraR_micro;
  logic registraR_macro;
  logic we_board;
  logic we_board_state;
  logic troca_jogador;
  logic contaT;
  logic contaS;

  // Selects
  logic sinal_macro;
  logic sinal_valida_macro;

  modport master (
    input  tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT, fimS,
    output zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM, zeraT, zeraS,
    output registraR_micro, registraR_macro, we_board, we_board_state,
    output troca_jogador, contaT, contaS,
    output sinal_macro, sinal_valida_macro
  );

  modport slave (
    output tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT, fimS,
    input  zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM, zeraT, zeraS,
    input  registraR_micro, registraR_macro, we_board, we_board_state,
    input  troca_jogador, contaT, contaS,
    input  sinal_macro, sinal_valida_macro
  );

endinterface

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore FSM sequencing one ultimate-tic-tac-toe game
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high, forces INICIAL
//   iniciar      start request (level), honoured only in INICIAL and FIM
//   dp           master side of the datapath control/status bundle
//   transmitindo high for the whole serial-transmit window
//   pronto       high in FIM
//   db_estado    current state code
module unidade_controle_jogo
  import jogo_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            iniciar,
  unidade_controle_jogo_if.master         dp,
  output logic                            transmitindo,
  output logic                            pronto,
  output logic [4:0]                      db_estado
);

  logic [4:0] estado;
  logic [4:0] proximo;
  controle_t  ctl;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic. tem_jogada is only looked at in the two espera states,
  // so a button press anywhere else is dropped rather than queued.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:            if (iniciar) proximo = PREPARACAO;
      PREPARACAO:         proximo = ESPERA_MACRO;
      ESPERA_MACRO:       if (dp.tem_jogada) proximo = REGISTRA_MACRO;
      REGISTRA_MACRO:     proximo = VALIDA_MACRO;
      VALIDA_MACRO:       proximo = dp.macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
      ESPERA_MICRO:       if (dp.tem_jogada) proximo = REGISTRA_MICRO;
      REGISTRA_MICRO:     proximo = VALIDA_MICRO;
      VALIDA_MICRO:       proximo = dp.micro_jogada ? ESPERA_MICRO : REGISTRA_JOGADA;
      REGISTRA_JOGADA:    proximo = ATUALIZA_MACRO;
      ATUALIZA_MACRO:     proximo = ESPERA_ATUALIZACAO;
      ESPERA_ATUALIZACAO: if (dp.fimT) proximo = TRANSMITE;
      TRANSMITE:          if (dp.fimS) proximo = VERIFICA_FIM;
      VERIFICA_FIM:       proximo = dp.fim_jogo ? FIM : TROCA;
      TROCA:              proximo = VALIDA_PROXIMA;
      // The micro cell just played names the next macro board; if that board
      // is already decided the opponent gets a free choice instead.
      VALIDA_PROXIMA:     proximo = dp.macro_vencida ? ESPERA_MACRO : REGISTRA_PROXIMA;
      REGISTRA_PROXIMA:   proximo = ESPERA_MICRO;
      FIM:                if (iniciar) proximo = PREPARACAO;
      default:            proximo = INICIAL;
    endcase
  end

  assign ctl = decodifica(estado);

  assign dp.zeraEdge           = ctl.zera_edge;
  assign dp.zeraR_micro        = ctl.zera_r_micro;
  assign dp.zeraR_macro        = ctl.zera_r_macro;
  assign dp.zeraFlipFlopT      = ctl.zera_flip_flop_t;
  assign dp.zeraRAM            = ctl.zera_ram;
  assign dp.zeraT              = ctl.zera_t;
  assign dp.zeraS              = ctl.zera_s;
  assign dp.registraR_micro    = ctl.registra_r_micro;
  assign dp.registraR_macro    = ctl.registra_r_macro;
  assign dp.we_board           = ctl.we_board;
  assign dp.we_board_state     = ctl.we_board_state;
  assign dp.troca_jogador      = ctl.troca_jogador;
  assign dp.contaT             = ctl.conta_t;
  assign dp.contaS             = ctl.conta_s;
  assign dp.sinal_macro        = ctl.sinal_macro;
  assign dp.sinal_valida_macro = ctl.sinal_valida_macro;

  assign transmitindo = ctl.transmitindo;
  assign pronto       = ctl.pronto;
  assign db_estado    = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - self-checking bench for unidade_controle_jogo
module tb_unidade_controle_jogo;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       transmitindo;
  logic       pronto;
  logic [4:0] db_estado;

  unidade_controle_jogo_if dp_if ();

  unidade_controle_jogo dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .dp           (dp_if),
    .transmitindo (transmitindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Datapath counters stand-in: settle = 90 cycles, transmit = 110 cycles.
  int cnt_t = 0;
  int cnt_s = 0;
  always @(posedge clock) begin
    if (reset || dp_if.zeraT) cnt_t <= 0;
    else if (dp_if.contaT)    cnt_t <= cnt_t + 1;
    if (reset || dp_if.zeraS) cnt_s <= 0;
    else if (dp_if.contaS)    cnt_s <= cnt_s + 1;
  end
  assign dp_if.fimT = (cnt_t == 89);
  assign dp_if.fimS = (cnt_s == 109);

  // Pulse monitors
  int we_cnt    = 0;
  int troca_cnt = 0;
  always @(negedge clock) begin
    if (dp_if.we_board)      we_cnt    <= we_cnt + 1;
    if (dp_if.troca_jogador) troca_cnt <= troca_cnt + 1;
  end

  // Model bookkeeping
  bit need_macro = 1'b1;
  int writes     = 0;
  int swaps      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected output word for a state, straight from the state/output table.
  function automatic logic [17:0] exp_out(input logic [4:0] c);
    logic z_all, z_t, z_s, r_mi, r_ma, we, wes, tr, ct, cs, sm, svm, tx, pr;
    z_all = (c == 5'h01);
    z_t   = (c == 5'h01) || (c == 5'h08);
    z_s   = (c == 5'h01) || (c == 5'h09);
    r_mi  = (c == 5'h06);
    r_ma  = (c == 5'h03) || (c == 5'h0F);
    we    = (c == 5'h08);
    wes   = (c == 5'h09);
    tr    = (c == 5'h0D);
    ct    = (c == 5'h0A);
    cs    = (c == 5'h0B);
    sm    = (c == 5'h02) || (c == 5'h03);
    svm   = (c == 5'h04) || (c == 5'h09);
    tx    = (c == 5'h0B);
    pr    = (c == 5'h10);
    return {z_all, z_all, z_all, z_all, z_all, z_t, z_s,
            r_mi, r_ma, we, wes, tr, ct, cs, sm, svm, tx, pr};
  endfunction

  function automatic logic [17:0] obs_out();
    return {dp_if.zeraEdge, dp_if.zeraR_micro, dp_if.zeraR_macro, dp_if.zeraFlipFlopT,
            dp_if.zeraRAM, dp_if.zeraT, dp_if.zeraS,
            dp_if.registraR_micro, dp_if.registraR_macro, dp_if.we_board,
            dp_if.we_board_state, dp_if.troca_jogador, dp_if.contaT, dp_if.contaS,
            dp_if.sinal_macro, dp_if.sinal_valida_macro, transmitindo, pronto};
  endfunction

  // One clock cycle: drive inputs, check the state we expect to be in now,
  // then advance to just after the next rising edge.
  task automatic step(input logic [4:0] code, input bit tj, input bit mv,
                      input bit mj, input bit fj, input bit ini);
    dp_if.tem_jogada    = tj;
    dp_if.macro_vencida = mv;
    dp_if.micro_jogada  = mj;
    dp_if.fim_jogo      = fj;
    iniciar             = ini;
    check("estado", 32'(db_estado), 32'(code));
    check("saidas", 32'(obs_out()), 32'(exp_out(code)));
    @(posedge clock);
    #1;
  endtask

  // One move from the player's point of view. rej_macro: rejected macro picks
  // before an accepted one; ocupadas: occupied-cell attempts; vencida_prox:
  // target board already won; fim_j: this move ends the game; abort: reset
  // during transmite cycle 50.
  task automatic jogada(input int rej_macro, input int ocupadas, input bit vencida_prox,
                        input bit fim_j, input bit abort);
    if (need_macro) begin
      for (int r = 0; r <= rej_macro; r++) begin
        repeat ($urandom_range(0, 3)) step(5'h02, 1'b0, rb(), rb(), rb(), rb());
        step(5'h02, 1'b1, rb(), rb(), rb(), rb());
        step(5'h03, rb(), rb(), rb(), rb(), rb());
        step(5'h04, rb(), (r < rej_macro), rb(), rb(), rb());
      end
    end
    for (int o = 0; o <= ocupadas; o++) begin
      repeat ($urandom_range(0, 3)) step(5'h05, 1'b0, rb(), rb(), rb(), rb());
      step(5'h05, 1'b1, rb(), rb(), rb(), rb());
      step(5'h06, rb(), rb(), rb(), rb(), rb());
      step(5'h07, rb(), rb(), (o < ocupadas), rb(), rb());
    end
    step(5'h08, rb(), rb(), rb(), rb(), rb());
    writes++;
    step(5'h09, rb(), rb(), rb(), rb(), rb());
    for (int i = 0; i < 90; i++) step(5'h0A, rb(), rb(), rb(), rb(), rb());
    for (int i = 1; i <= 110; i++) begin
      if (abort && i == 50) begin
        reset = 1'b1;
        step(5'h0B, rb(), rb(), rb(), rb(), rb());
        reset = 1'b0;
        need_macro = 1'b1;
        return;
      end
      step(5'h0B, rb(), rb(), rb(), rb(), rb());
    end
    step(5'h0C, rb(), rb(), rb(), fim_j, rb());
    if (fim_j) begin
      need_macro = 1'b1;
      return;
    end
    step(5'h0D, rb(), rb(), rb(), rb(), rb());
    swaps++;
    step(5'h0E, rb(), vencida_prox, rb(), rb(), rb());
    if (vencida_prox) begin
      need_macro = 1'b1;
    end else begin
      step(5'h0F, rb(), rb(), rb(), rb(), rb());
      need_macro = 1'b0;
    end
  endtask

  task automatic partida();
    step(5'h00, rb(), rb(), rb(), rb(), 1'b1);
    step(5'h01, rb(), rb(), rb(), rb(), rb());
    need_macro = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    dp_if.tem_jogada = 1'b0;
    dp_if.macro_vencida = 1'b0;
    dp_if.micro_jogada = 1'b0;
    dp_if.fim_jogo = 1'b0;
    @(posedge clock);
    #1;
    step(5'h00, rb(), rb(), rb(), rb(), rb());
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(5'h00, 1'b1, rb(), rb(), rb(), 1'b0);
    partida();

    jogada(0, 0, 1'b0, 1'b0, 1'b0);
    jogada(0, 1, 1'b1, 1'b0, 1'b0);
    jogada(1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      jogada($urandom_range(0, 1), $urandom_range(0, 2),
             ($urandom_range(0, 2) == 0), 1'b0, 1'b0);
    jogada(0, 0, 1'b0, 1'b1, 1'b0);

    // Game over: held in FIM until iniciar, buttons ignored
    for (int i = 0; i < 4; i++) step(5'h10, rb(), rb(), rb(), rb(), 1'b0);
    step(5'h10, rb(), rb(), rb(), rb(), 1'b1);
    step(5'h01, rb(), rb(), rb(), rb(), rb());
    need_macro = 1'b1;

    // Reset in the middle of transmite
    jogada(0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(5'h00, 1'b1, rb(), rb(), rb(), 1'b0);
    partida();
    jogada(0, 0, 1'b1, 1'b0, 1'b0);
    jogada(0, 0, 1'b0, 1'b1, 1'b0);
    step(5'h10, rb(), rb(), rb(), rb(), 1'b0);

    check("we_board_pulses", 32'(we_cnt), 32'(writes));
    check("troca_pulses", 32'(troca_cnt), 32'(swaps));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
